tdm_mux_demux: RTL and testbench

Parametrised N-channel multiplexer/demultiplexer with registered outputs and valid/ready handshakes on every channel. Each path selects its channel either from an external select (manual mode) or from an internal round-robin pointer (auto/TDM scan mode). It is the clocked, flow-controlled successor to the team's 4:1/1:4 combinational mux/demux. It sits between multiple channel sources/sinks and a single shared serial datapath.

---
 rtl/tdm_mux_demux.sv | 186 ++++++++++++++++++
 tb/tb_tdm_mux_demux.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_demux.sv
// N-channel clocked mux/demux with valid/ready per channel; manual select or round-robin TDM scan.
// Define RR_SKIP_EN to let the auto-mode mux skip idle channels instead of emitting bubbles.
module tdm_mux_demux #(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_CH*WIDTH-1:0]   mux_in_data,
  input  logic [N_CH-1:0]         mux_in_valid,
  output logic [N_CH-1:0]         mux_in_ready,
  output logic [WIDTH-1:0]        mux_out_data,
  output logic [SEL_W-1:0]        mux_out_ch,
  output logic                    mux_out_valid,
  input  logic                    mux_out_ready,
  output logic [SEL_W-1:0]        mux_ptr,
  input  logic [WIDTH-1:0]        dmx_in_data,
  input  logic                    dmx_in_valid,
  output logic                    dmx_in_ready,
  output logic [N_CH*WIDTH-1:0]   dmx_out_data,
  output logic [N_CH-1:0]         dmx_out_valid,
  input  logic [N_CH-1:0]         dmx_out_ready,
  output logic [SEL_W-1:0]        dmx_ptr
);

  // Pointer increment with wrap at N_CH-1, valid for non-power-of-two channel counts.
  function automatic logic [SEL_W-1:0] inc_wrap(input logic [SEL_W-1:0] v);
    return (v == SEL_W'(N_CH - 1)) ? '0 : v + SEL_W'(1);
  endfunction

  logic [N_CH-1:0][WIDTH-1:0] mux_in_arr;

  logic                       mux_valid_q, mux_valid_d;
  logic [WIDTH-1:0]           mux_data_q,  mux_data_d;
  logic [SEL_W-1:0]           mux_ch_q,    mux_ch_d;
  logic [SEL_W-1:0]           mux_ptr_q,   mux_ptr_d;

  logic [N_CH-1:0]            dmx_valid_q, dmx_valid_d;
  logic [N_CH-1:0][WIDTH-1:0] dmx_data_q,  dmx_data_d;
  logic [SEL_W-1:0]           dmx_ptr_q,   dmx_ptr_d;

  logic [SEL_W-1:0]           mux_c;
  logic                       mux_sel_valid;
  logic [WIDTH-1:0]           mux_sel_data;
  logic                       mux_slot;
  logic                       mux_accept;

  logic [SEL_W-1:0]           dmx_c;
  logic                       dmx_accept;

  assign mux_in_arr = mux_in_data;

`ifdef RR_SKIP_EN
  logic                       skip_found;
  logic [SEL_W:0]             skip_cand;

  // Auto mode: first valid channel at or after the pointer, cyclically; pointer itself if none.
  always_comb begin
    mux_c      = mode ? mux_ptr_q : sel;
    skip_found = 1'b0;
    skip_cand  = '0;
    if (mode) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        skip_cand = {1'b0, mux_ptr_q} + (SEL_W+1)'(i);
        if (skip_cand >= (SEL_W+1)'(N_CH)) begin
          skip_cand = skip_cand - (SEL_W+1)'(N_CH);
        end
        for (int unsigned k = 0; k < N_CH; k++) begin
          if (!skip_found && (skip_cand == (SEL_W+1)'(k)) && mux_in_valid[k]) begin
            skip_found = 1'b1;
            mux_c      = SEL_W'(k);
          end
        end
      end
    end
  end
`else
  assign mux_c = mode ? mux_ptr_q : sel;
`endif

  assign mux_slot = !mux_valid_q || mux_out_ready;

  // Decode the effective mux channel; an out-of-range select matches no channel.
  always_comb begin
    mux_sel_valid = 1'b0;
    mux_sel_data  = '0;
    mux_in_ready  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (mux_c == SEL_W'(k)) begin
        mux_sel_valid   = mux_in_valid[k];
        mux_sel_data    = mux_in_arr[k];
        mux_in_ready[k] = rst_n && mux_slot;
      end
    end
  end

  assign mux_accept = rst_n && mux_slot && mux_sel_valid;

  always_comb begin
    mux_valid_d = mux_valid_q;
    mux_data_d  = mux_data_q;
    mux_ch_d    = mux_ch_q;
    mux_ptr_d   = mux_ptr_q;
    if (mux_accept) begin
      mux_valid_d = 1'b1;
      mux_data_d  = mux_sel_data;
      mux_ch_d    = mux_c;
    end else if (mux_out_ready) begin
      mux_valid_d = 1'b0;
    end
`ifdef RR_SKIP_EN
    if (mode && mux_accept) begin
      mux_ptr_d = inc_wrap(mux_c);
    end
`else
    // Strict TDM: every slot consumes a pointer position, valid or not.
    if (mode && mux_slot) begin
      mux_ptr_d = inc_wrap(mux_ptr_q);
    end
`endif
  end

  assign dmx_c = mode ? dmx_ptr_q : sel;

  always_comb begin
    dmx_in_ready = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (dmx_c == SEL_W'(k)) begin
        dmx_in_ready = rst_n && (!dmx_valid_q[k] || dmx_out_ready[k]);
      end
    end
  end

  assign dmx_accept = dmx_in_valid && dmx_in_ready;

  // Per-channel drain and reload; a reload in the drain cycle keeps the channel valid.
  always_comb begin
    dmx_valid_d = dmx_valid_q;
    dmx_data_d  = dmx_data_q;
    dmx_ptr_d   = dmx_ptr_q;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (dmx_out_ready[k]) begin
        dmx_valid_d[k] = 1'b0;
      end
      if (dmx_accept && (dmx_c == SEL_W'(k))) begin
        dmx_valid_d[k] = 1'b1;
        dmx_data_d[k]  = dmx_in_data;
      end
    end
    if (mode && dmx_accept) begin
      dmx_ptr_d = inc_wrap(dmx_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mux_valid_q <= 1'b0;
      mux_data_q  <= '0;
      mux_ch_q    <= '0;
      mux_ptr_q   <= '0;
      dmx_valid_q <= '0;
      dmx_data_q  <= '0;
      dmx_ptr_q   <= '0;
    end else begin
      mux_valid_q <= mux_valid_d;
      mux_data_q  <= mux_data_d;
      mux_ch_q    <= mux_ch_d;
      mux_ptr_q   <= mux_ptr_d;
      dmx_valid_q <= dmx_valid_d;
      dmx_data_q  <= dmx_data_d;
      dmx_ptr_q   <= dmx_ptr_d;
    end
  end

  assign mux_out_valid = mux_valid_q;
  assign mux_out_data  = mux_data_q;
  assign mux_out_ch    = mux_ch_q;
  assign mux_ptr       = mux_ptr_q;
  assign dmx_out_valid = dmx_valid_q;
  assign dmx_out_data  = dmx_data_q;
  assign dmx_ptr       = dmx_ptr_q;

endmodule

// File: tb/tb_tdm_mux_demux.sv
// Scoreboard bench for tdm_mux_demux: a 4-channel instance for the main paths, a 3-channel one for out-of-range select.
module tb_tdm_mux_demux;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] mi_data;
  logic [N-1:0]   mi_valid;
  logic [N-1:0]   mi_ready;
  logic [W-1:0]   mo_data;
  logic [1:0]     mo_ch;
  logic           mo_valid;
  logic           mo_ready;
  logic [1:0]     mux_ptr;
  logic [W-1:0]   di_data;
  logic           di_valid;
  logic           di_ready;
  logic [N*W-1:0] do_data;
  logic [N-1:0]   do_valid;
  logic [N-1:0]   do_ready;
  logic [1:0]     dmx_ptr;

  logic           rst3_n;
  logic           t_mode;
  logic [1:0]     t_sel;
  logic [3*W-1:0] t_mi_data;
  logic [2:0]     t_mi_valid;
  logic [2:0]     t_mi_ready;
  logic [W-1:0]   t_mo_data;
  logic [1:0]     t_mo_ch;
  logic           t_mo_valid;
  logic           t_mo_ready;
  logic [1:0]     t_mux_ptr;
  logic [W-1:0]   t_di_data;
  logic           t_di_valid;
  logic           t_di_ready;
  logic [3*W-1:0] t_do_data;
  logic [2:0]     t_do_valid;
  logic [2:0]     t_do_ready;
  logic [1:0]     t_dmx_ptr;

  tdm_mux_demux #(.N_CH(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .mux_in_data(mi_data), .mux_in_valid(mi_valid), .mux_in_ready(mi_ready),
    .mux_out_data(mo_data), .mux_out_ch(mo_ch), .mux_out_valid(mo_valid),
    .mux_out_ready(mo_ready), .mux_ptr(mux_ptr),
    .dmx_in_data(di_data), .dmx_in_valid(di_valid), .dmx_in_ready(di_ready),
    .dmx_out_data(do_data), .dmx_out_valid(do_valid), .dmx_out_ready(do_ready),
    .dmx_ptr(dmx_ptr)
  );

  tdm_mux_demux #(.N_CH(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .mode(t_mode), .sel(t_sel),
    .mux_in_data(t_mi_data), .mux_in_valid(t_mi_valid), .mux_in_ready(t_mi_ready),
    .mux_out_data(t_mo_data), .mux_out_ch(t_mo_ch), .mux_out_valid(t_mo_valid),
    .mux_out_ready(t_mo_ready), .mux_ptr(t_mux_ptr),
    .dmx_in_data(t_di_data), .dmx_in_valid(t_di_valid), .dmx_in_ready(t_di_ready),
    .dmx_out_data(t_do_data), .dmx_out_valid(t_do_valid), .dmx_out_ready(t_do_ready),
    .dmx_ptr(t_dmx_ptr)
  );

  int    checks   = 0;
  int    failures = 0;
  beat_t mq[$];
  beat_t dq[$];
  beat_t me;
  beat_t de;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_m(input logic [7:0] ch, input logic [7:0] data);
    mq.push_back('{ch: ch, data: data});
  endtask

  task automatic push_d(input logic [7:0] ch, input logic [7:0] data);
    dq.push_back('{ch: ch, data: data});
  endtask

  // Output monitor: every consumed beat is popped from its scoreboard queue and compared.
  always @(negedge clk) begin
    if (rst_n && mo_valid && mo_ready) begin
      checks++;
      if (mq.size() == 0) begin
        failures++;
        $display("FAIL mux_beat unexpected ch=%0d data=%0h @%0t", mo_ch, mo_data, $time);
      end else begin
        me = mq.pop_front();
        if (mo_ch !== me.ch[1:0] || mo_data !== me.data) begin
          failures++;
          $display("FAIL mux_beat actual ch=%0d data=%0h expected ch=%0d data=%0h @%0t",
                   mo_ch, mo_data, me.ch, me.data, $time);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (rst_n && do_valid[k] && do_ready[k]) begin
        checks++;
        if (dq.size() == 0) begin
          failures++;
          $display("FAIL dmx_beat unexpected ch=%0d data=%0h @%0t", k, do_data[k*W +: W], $time);
        end else begin
          de = dq.pop_front();
          if (8'(k) !== de.ch || do_data[k*W +: W] !== de.data) begin
            failures++;
            $display("FAIL dmx_beat actual ch=%0d data=%0h expected ch=%0d data=%0h @%0t",
                     k, do_data[k*W +: W], de.ch, de.data, $time);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    mode = 1'b0; sel = 2'd0;
    mi_data = 32'h5A3C_7E11; mi_valid = 4'hF; mo_ready = 1'b1;
    di_data = 8'hEE; di_valid = 1'b1; do_ready = 4'h0;
    t_mode = 1'b0; t_sel = 2'd0; t_mi_data = '0; t_mi_valid = '0; t_mo_ready = 1'b0;
    t_di_data = '0; t_di_valid = 1'b0; t_do_ready = '0;

    // Reset with live handshakes
    tick(); tick();
    chk("rst_mo_valid", 32'(mo_valid), 32'd0);
    chk("rst_mo_data",  32'(mo_data),  32'd0);
    chk("rst_mo_ch",    32'(mo_ch),    32'd0);
    chk("rst_mux_ptr",  32'(mux_ptr),  32'd0);
    chk("rst_dmx_ptr",  32'(dmx_ptr),  32'd0);
    chk("rst_do_valid", 32'(do_valid), 32'd0);
    chk("rst_do_data",  do_data,       32'd0);
    chk("rst_mi_ready", 32'(mi_ready), 32'd0);
    chk("rst_di_ready", 32'(di_ready), 32'd0);
    mi_valid = 4'h0; di_valid = 1'b0; mi_data = '0;
    rst_n = 1'b1;
    tick();

    // Manual mux with backpressure
    sel = 2'd2; mi_data = 32'h00A5_0000; mi_valid = 4'b0100; mo_ready = 1'b1;
    #1 chk("man_mi_ready", 32'(mi_ready), 32'h4);
    push_m(8'd2, 8'hA5);
    tick();
    chk("man_mo_valid", 32'(mo_valid), 32'd1);
    chk("man_mo_data",  32'(mo_data),  32'hA5);
    chk("man_mo_ch",    32'(mo_ch),    32'd2);
    mo_ready = 1'b0; mi_data = 32'h005A_0000;
    #1 chk("stall_mi_ready", 32'(mi_ready), 32'h0);
    tick();
    chk("stall_mo_data",  32'(mo_data),  32'hA5);
    chk("stall_mo_ch",    32'(mo_ch),    32'd2);
    chk("stall_mo_valid", 32'(mo_valid), 32'd1);
    chk("stall_mi_ready", 32'(mi_ready), 32'h0);
    push_m(8'd2, 8'h5A);
    mo_ready = 1'b1;
    #1 chk("resume_mi_ready", 32'(mi_ready), 32'h4);
    tick();
    mi_valid = 4'h0;
    chk("resume_mo_data", 32'(mo_data), 32'h5A);
    tick();
    chk("drain_mo_valid", 32'(mo_valid), 32'd0);
    chk("man_mux_ptr",    32'(mux_ptr),  32'd0);

    // Auto scan, all channels valid
    mode = 1'b1; mi_data = 32'h1312_1110; mi_valid = 4'hF;
    push_m(8'd0, 8'h10); push_m(8'd1, 8'h11); push_m(8'd2, 8'h12);
    push_m(8'd3, 8'h13); push_m(8'd0, 8'h10);
    repeat (5) tick();
    mi_valid = 4'h0;
    chk("scan_ptr_after5", 32'(mux_ptr), 32'd1);
    repeat (3) tick();
    chk("idle_mo_valid", 32'(mo_valid), 32'd0);
`ifdef RR_SKIP_EN
    chk("idle_ptr_holds", 32'(mux_ptr), 32'd1);
    mi_valid = 4'b1000;
    push_m(8'd3, 8'h13);
    tick();
    mi_valid = 4'h0;
    tick();
    chk("skip_ptr_wrap", 32'(mux_ptr), 32'd0);
`else
    chk("idle_ptr_advances", 32'(mux_ptr), 32'd0);
`endif

    // Auto scan with channel 1 idle
    mi_valid = 4'b1101;
`ifdef RR_SKIP_EN
    push_m(8'd0, 8'h10); push_m(8'd2, 8'h12); push_m(8'd3, 8'h13); push_m(8'd0, 8'h10);
`else
    push_m(8'd0, 8'h10); push_m(8'd2, 8'h12); push_m(8'd3, 8'h13);
`endif
    tick(); tick();
`ifdef RR_SKIP_EN
    chk("skip_no_bubble", 32'(mo_valid), 32'd1);
    chk("skip_data",      32'(mo_data),  32'h12);
    chk("skip_ptr",       32'(mux_ptr),  32'd3);
`else
    chk("bubble_mo_valid", 32'(mo_valid), 32'd0);
    chk("bubble_ptr",      32'(mux_ptr),  32'd2);
`endif
    tick(); tick();
    mi_valid = 4'h0;
`ifdef RR_SKIP_EN
    chk("ch1idle_end_ptr", 32'(mux_ptr), 32'd1);
`else
    chk("ch1idle_end_ptr", 32'(mux_ptr), 32'd0);
`endif
    tick(); tick();

    // Auto demux fill with no downstream ready, then drain-and-reload
    do_ready = 4'h0;
    chk("dmx_ptr_start", 32'(dmx_ptr), 32'd0);
    di_valid = 1'b1; di_data = 8'hC0;
    #1 chk("dmx_ready_empty", 32'(di_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      di_data = 8'hC0 + 8'(i);
      tick();
    end
    di_valid = 1'b0;
    #1;
    chk("dmx_full_valid", 32'(do_valid), 32'hF);
    chk("dmx_full_data",  do_data,       32'hC3C2_C1C0);
    chk("dmx_full_ptr",   32'(dmx_ptr),  32'd0);
    chk("dmx_full_ready", 32'(di_ready), 32'd0);
    push_d(8'd0, 8'hC0);
    do_ready = 4'b0001; di_valid = 1'b1; di_data = 8'hC4;
    #1 chk("dmx_reload_ready", 32'(di_ready), 32'd1);
    tick();
    do_ready = 4'h0; di_valid = 1'b0;
    #1;
    chk("dmx_reload_valid", 32'(do_valid),     32'hF);
    chk("dmx_reload_data",  32'(do_data[7:0]), 32'hC4);
    chk("dmx_reload_ptr",   32'(dmx_ptr),      32'd1);
    push_d(8'd0, 8'hC4); push_d(8'd1, 8'hC1); push_d(8'd2, 8'hC2); push_d(8'd3, 8'hC3);
    do_ready = 4'hF;
    tick();
    do_ready = 4'h0;
    chk("dmx_drained_valid", 32'(do_valid), 32'd0);

    // Three-channel instance: out-of-range select, then reset over a valid output
    rst3_n = 1'b1; t_mode = 1'b0; t_sel = 2'd3;
    t_mi_data = 24'h66_77_55; t_mi_valid = 3'b111; t_mo_ready = 1'b1;
    t_di_valid = 1'b1; t_di_data = 8'h99; t_do_ready = 3'b000;
    #1;
    chk("oor_mi_ready", 32'(t_mi_ready), 32'd0);
    chk("oor_di_ready", 32'(t_di_ready), 32'd0);
    tick();
    chk("oor_mo_valid", 32'(t_mo_valid), 32'd0);
    chk("oor_do_valid", 32'(t_do_valid), 32'd0);
    chk("oor_dmx_ptr",  32'(t_dmx_ptr),  32'd0);
    t_sel = 2'd1; t_mo_ready = 1'b0;
    #1 chk("n3_mi_ready", 32'(t_mi_ready), 32'h2);
    tick();
    chk("n3_mo_valid", 32'(t_mo_valid),       32'd1);
    chk("n3_mo_data",  32'(t_mo_data),        32'h77);
    chk("n3_mo_ch",    32'(t_mo_ch),          32'd1);
    chk("n3_do_valid", 32'(t_do_valid),       32'h2);
    chk("n3_do_data",  32'(t_do_data[15:8]),  32'h99);
    rst3_n = 1'b0;
    #1 chk("n3_rst_mi_ready", 32'(t_mi_ready), 32'd0);
    tick();
    chk("n3_rst_mo_valid", 32'(t_mo_valid), 32'd0);
    chk("n3_rst_mo_data",  32'(t_mo_data),  32'd0);
    chk("n3_rst_do_valid", 32'(t_do_valid), 32'd0);
    chk("n3_rst_mux_ptr",  32'(t_mux_ptr),  32'd0);

    chk("mux_sb_empty", 32'(mq.size()), 32'd0);
    chk("dmx_sb_empty", 32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
